// File: rtl/exponent_process_fp_param_if.sv
// Handshake/data bundle between the FP mul/div control and the exponent datapath.
// The mantissa pipeline owns norm_adj; it is carried here so the datapath sees one bus.
interface exponent_process_fp_param_if #(
    parameter int EXP_W = 8
);
    logic             valid_in;
    logic             op_div;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic             norm_adj;
    logic             valid_out;
    logic [EXP_W-1:0] exponent;
    logic             zero_flag;
    logic             inf_flag;
    logic             nan_flag;

    modport master (
        output valid_in, op_div, exp_a, exp_b, norm_adj,
        input  valid_out, exponent, zero_flag, inf_flag, nan_flag
    );

    modport slave (
        input  valid_in, op_div, exp_a, exp_b, norm_adj,
        output valid_out, exponent, zero_flag, inf_flag, nan_flag
    );
endinterface

// File: rtl/exponent_process_fp_param.sv
// Exponent datapath for FP multiply/divide: combine, re-bias, align delay,
// late normalise and classify. Latency is 4 + ALIGN_DLY clocks.
module exponent_process_fp_param #(
    parameter int EXP_W     = 8,
    parameter int BIAS      = 2**(EXP_W-1)-1,
    parameter int ALIGN_DLY = 2
) (
    input logic                        clk,
    input logic                        rst,
    exponent_process_fp_param_if.slave io
);
    localparam int W = EXP_W + 2;
    localparam logic [W-1:0]     BIAS_W = W'(BIAS);
    localparam logic [W-1:0]     MAX_W  = W'((2**EXP_W) - 1);
    localparam logic [W-1:0]     ONE_W  = W'(1);
    localparam logic [EXP_W-1:0] ONES   = '1;

    typedef struct packed {
        logic         v;
        logic         op;
        logic         az;
        logic         bz;
        logic         ai;
        logic         bi;
        logic [W-1:0] x;
    } stg_t;

    stg_t s1_q, s1_d;
    stg_t s2_d;
    stg_t pipe_q [ALIGN_DLY+1];
    stg_t nrm_q, nrm_d;

    logic             vout_q;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             zf_q, zf_d;
    logic             if_q, if_d;
    logic             nf_q, nf_d;

    always_comb begin
        s1_d   = s1_q;
        s1_d.v = io.valid_in;
        if (io.valid_in) begin
            s1_d.op = io.op_div;
            s1_d.az = (io.exp_a == '0);
            s1_d.bz = (io.exp_b == '0);
            s1_d.ai = (io.exp_a == ONES);
            s1_d.bi = (io.exp_b == ONES);
            s1_d.x  = io.op_div ? {2'b00, io.exp_a} - {2'b00, io.exp_b}
                                : {2'b00, io.exp_a} + {2'b00, io.exp_b};
        end
    end

    always_comb begin
        s2_d   = pipe_q[0];
        s2_d.v = s1_q.v;
        if (s1_q.v) begin
            s2_d   = s1_q;
            s2_d.x = s1_q.op ? s1_q.x + BIAS_W : s1_q.x - BIAS_W;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            for (int k = 0; k <= ALIGN_DLY; k++) pipe_q[k] <= '0;
        end else begin
            s1_q      <= s1_d;
            pipe_q[0] <= s2_d;
            // Alignment stages: valid always shifts, payload only on valid.
            for (int k = 1; k <= ALIGN_DLY; k++) begin
                pipe_q[k].v <= pipe_q[k-1].v;
                if (pipe_q[k-1].v) pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    always_comb begin
        nrm_d   = nrm_q;
        nrm_d.v = pipe_q[ALIGN_DLY].v;
        if (pipe_q[ALIGN_DLY].v) begin
            nrm_d = pipe_q[ALIGN_DLY];
            if (io.norm_adj)
                nrm_d.x = nrm_d.op ? nrm_d.x - ONE_W : nrm_d.x + ONE_W;
        end
    end

    logic nan_c, inf_c, zero_c, uf_c, of_c;

    always_comb begin
        nan_c  = nrm_q.op ? (nrm_q.az & nrm_q.bz) | (nrm_q.ai & nrm_q.bi)
                          : (nrm_q.az | nrm_q.bz) & (nrm_q.ai | nrm_q.bi);
        inf_c  = nrm_q.op ? nrm_q.ai | nrm_q.bz : nrm_q.ai | nrm_q.bi;
        zero_c = nrm_q.op ? nrm_q.az | nrm_q.bi : nrm_q.az | nrm_q.bz;
        uf_c   = nrm_q.x[W-1] | (nrm_q.x == '0);
        of_c   = ~nrm_q.x[W-1] & (nrm_q.x >= MAX_W);

        exp_d = exp_q;
        zf_d  = zf_q;
        if_d  = if_q;
        nf_d  = nf_q;
        if (nrm_q.v) begin
            exp_d = '0;
            zf_d  = 1'b0;
            if_d  = 1'b0;
            nf_d  = 1'b0;
            if (nan_c) begin
                nf_d  = 1'b1;
                exp_d = ONES;
            end else if (inf_c) begin
                if_d  = 1'b1;
                exp_d = ONES;
            end else if (zero_c || uf_c) begin
                zf_d  = 1'b1;
            end else if (of_c) begin
                if_d  = 1'b1;
                exp_d = ONES;
            end else begin
                exp_d = nrm_q.x[EXP_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nrm_q  <= '0;
            vout_q <= 1'b0;
            exp_q  <= '0;
            zf_q   <= 1'b0;
            if_q   <= 1'b0;
            nf_q   <= 1'b0;
        end else begin
            nrm_q  <= nrm_d;
            vout_q <= nrm_q.v;
            exp_q  <= exp_d;
            zf_q   <= zf_d;
            if_q   <= if_d;
            nf_q   <= nf_d;
        end
    end

    assign io.valid_out = vout_q;
    assign io.exponent  = exp_q;
    assign io.zero_flag = zf_q;
    assign io.inf_flag  = if_q;
    assign io.nan_flag  = nf_q;
endmodule

// File: tb/tb_exponent_process_fp_param.sv
// Directed and streaming checks for exponent_process_fp_param
// in FP32, FP16 and FP64 configurations.
module tb_exponent_process_fp_param;
    localparam int L32 = 6;
    localparam int NS  = 28;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    exponent_process_fp_param_if #(.EXP_W(8))  b32 ();
    exponent_process_fp_param_if #(.EXP_W(5))  b16 ();
    exponent_process_fp_param_if #(.EXP_W(11)) b64 ();

    exponent_process_fp_param #(.EXP_W(8), .ALIGN_DLY(2)) u32 (
        .clk(clk), .rst(rst), .io(b32)
    );
    exponent_process_fp_param #(.EXP_W(5), .ALIGN_DLY(0)) u16 (
        .clk(clk), .rst(rst), .io(b16)
    );
    exponent_process_fp_param #(.EXP_W(11), .ALIGN_DLY(3)) u64 (
        .clk(clk), .rst(rst), .io(b64)
    );

    function automatic void model(input int ew, input int bias,
                                  input int a, input int b,
                                  input bit op, input bit adj,
                                  output int e, output bit z,
                                  output bit i, output bit n);
        int  maxv, r;
        bit  az, bz, ai, bi;
        maxv = (1 << ew) - 1;
        az = (a == 0); bz = (b == 0);
        ai = (a == maxv); bi = (b == maxv);
        r = op ? a - b + bias : a + b - bias;
        if (adj) r = op ? r - 1 : r + 1;
        n = 0; i = 0; z = 0; e = 0;
        if (op ? ((az && bz) || (ai && bi)) : ((az || bz) && (ai || bi))) begin
            n = 1; e = maxv;
        end else if (op ? (ai || bz) : (ai || bi)) begin
            i = 1; e = maxv;
        end else if (op ? (az || bi) : (az || bz)) begin
            z = 1;
        end else if (r <= 0) begin
            z = 1;
        end else if (r >= maxv) begin
            i = 1; e = maxv;
        end else begin
            e = r;
        end
    endfunction

    task automatic run32(input string nm, input logic [7:0] a,
                         input logic [7:0] b, input logic op,
                         input logic adj, input logic [7:0] ee,
                         input logic z, input logic i, input logic n);
        int cyc;
        b32.exp_a = a; b32.exp_b = b; b32.op_div = op;
        b32.valid_in = 1'b1; b32.norm_adj = !adj;
        @(posedge clk); #1;
        b32.valid_in = 1'b0; b32.exp_a = ~a; b32.op_div = !op;
        cyc = 1;
        while (!b32.valid_out && cyc < 20) begin
            b32.norm_adj = (cyc == L32 - 2) ? adj : !adj;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== L32)
            $display("FAIL %s latency: got %0d want %0d", nm, cyc, L32);
        if (cyc !== L32) errs++;
        checks++;
        if ({b32.valid_out, b32.nan_flag, b32.inf_flag, b32.zero_flag, b32.exponent}
            !== {1'b1, n, i, z, ee}) begin
            errs++;
            $display("FAIL %s result: got v=%b n=%b i=%b z=%b e=%0d want n=%b i=%b z=%b e=%0d",
                     nm, b32.valid_out, b32.nan_flag, b32.inf_flag, b32.zero_flag,
                     b32.exponent, n, i, z, ee);
        end
        @(posedge clk); #1;
        checks++;
        if ({b32.valid_out, b32.nan_flag, b32.inf_flag, b32.zero_flag, b32.exponent}
            !== {1'b0, n, i, z, ee}) begin
            errs++;
            $display("FAIL %s hold: got v=%b e=%0d want v=0 e=%0d",
                     nm, b32.valid_out, b32.exponent, ee);
        end
        b32.norm_adj = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({b32.valid_out, b32.exponent, b32.zero_flag, b32.inf_flag, b32.nan_flag} !== '0) begin
            errs++;
            $display("FAIL reset32: got v=%b e=%0d", b32.valid_out, b32.exponent);
        end
        checks++;
        if ({b16.valid_out, b16.exponent, b16.zero_flag, b16.inf_flag, b16.nan_flag} !== '0) begin
            errs++;
            $display("FAIL reset16: got v=%b e=%0d", b16.valid_out, b16.exponent);
        end
        checks++;
        if ({b64.valid_out, b64.exponent, b64.zero_flag, b64.inf_flag, b64.nan_flag} !== '0) begin
            errs++;
            $display("FAIL reset64: got v=%b e=%0d", b64.valid_out, b64.exponent);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        run32("mul_normal", 8'd130, 8'd127, 1'b0, 1'b0, 8'd130, 0, 0, 0);
        run32("mul_ovf",    8'd200, 8'd200, 1'b0, 1'b0, 8'd255, 0, 1, 0);
        run32("mul_unf",    8'd10,  8'd20,  1'b0, 1'b0, 8'd0,   1, 0, 0);
        run32("mul_adj",    8'd100, 8'd90,  1'b0, 1'b1, 8'd64,  0, 0, 0);
    endtask

    task automatic test_div();
        run32("div_adj",  8'd127, 8'd128, 1'b1, 1'b1, 8'd125, 0, 0, 0);
        run32("div_00",   8'd0,   8'd0,   1'b1, 1'b0, 8'd255, 0, 0, 1);
        run32("div_by0",  8'd5,   8'd0,   1'b1, 1'b0, 8'd255, 0, 1, 0);
        run32("div_binf", 8'd5,   8'd255, 1'b1, 1'b0, 8'd0,   1, 0, 0);
        run32("mul_0inf", 8'd0,   8'd255, 1'b0, 1'b0, 8'd255, 0, 0, 1);
    endtask

    task automatic test_boundary();
        run32("bnd_ovf255", 8'd127, 8'd254, 1'b0, 1'b1, 8'd255, 0, 1, 0);
        run32("bnd_ovf254", 8'd127, 8'd254, 1'b0, 1'b0, 8'd254, 0, 0, 0);
        run32("bnd_ne0",    8'd64,  8'd63,  1'b0, 1'b0, 8'd0,   1, 0, 0);
        run32("bnd_ne1",    8'd64,  8'd63,  1'b0, 1'b1, 8'd1,   0, 0, 0);
        run32("bnd_div1",   8'd1,   8'd127, 1'b1, 1'b1, 8'd0,   1, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic       sv [NS];
        logic       sop [NS];
        logic       sadj [NS];
        int         sa [NS];
        int         sb [NS];
        int         e, last_e;
        bit         z, i, n, lz, li, ln, seen;
        for (int k = 0; k < NS; k++) begin
            sv[k]   = !((k % 5 == 3) || (k == 11));
            sop[k]  = 1'($urandom_range(0, 1));
            sadj[k] = 1'($urandom_range(0, 1));
            sa[k]   = (k % 7 == 2) ? 0 : int'($urandom_range(40, 215));
            sb[k]   = (k % 9 == 4) ? 255 : int'($urandom_range(40, 215));
        end
        seen = 0; last_e = 0; lz = 0; li = 0; ln = 0;
        for (int c = 0; c < NS + L32; c++) begin
            if (c >= L32) begin
                int j;
                j = c - L32;
                if (sv[j]) begin
                    model(8, 127, sa[j], sb[j], sop[j], sadj[j], e, z, i, n);
                    checks++;
                    if ({b32.valid_out, b32.nan_flag, b32.inf_flag, b32.zero_flag, b32.exponent}
                        !== {1'b1, n, i, z, 8'(e)}) begin
                        errs++;
                        $display("FAIL stream tok%0d: got v=%b n=%b i=%b z=%b e=%0d want n=%b i=%b z=%b e=%0d",
                                 j, b32.valid_out, b32.nan_flag, b32.inf_flag, b32.zero_flag,
                                 b32.exponent, n, i, z, e);
                    end
                    last_e = e; lz = z; li = i; ln = n; seen = 1;
                end else if (seen) begin
                    checks++;
                    if ({b32.valid_out, b32.nan_flag, b32.inf_flag, b32.zero_flag, b32.exponent}
                        !== {1'b0, ln, li, lz, 8'(last_e)}) begin
                        errs++;
                        $display("FAIL stream gap%0d: got v=%b e=%0d want v=0 e=%0d",
                                 j, b32.valid_out, b32.exponent, last_e);
                    end
                end
            end
            if (c < NS) begin
                b32.valid_in = sv[c];
                b32.op_div   = sop[c];
                b32.exp_a    = 8'(sa[c]);
                b32.exp_b    = 8'(sb[c]);
            end else begin
                b32.valid_in = 1'b0;
            end
            if (c - (L32 - 2) >= 0 && c - (L32 - 2) < NS && sv[c - (L32 - 2)])
                b32.norm_adj = sadj[c - (L32 - 2)];
            else
                b32.norm_adj = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        b32.valid_in = 1'b0;
        b32.norm_adj = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int stray;
        run32("pre_rst", 8'd130, 8'd127, 1'b0, 1'b0, 8'd130, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            b32.exp_a = 8'(140 + k); b32.exp_b = 8'd127;
            b32.op_div = 1'b0; b32.valid_in = 1'b1;
            @(posedge clk); #1;
        end
        b32.valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({b32.valid_out, b32.exponent, b32.zero_flag, b32.inf_flag, b32.nan_flag} !== '0) begin
            errs++;
            $display("FAIL rst_async: got v=%b e=%0d want 0", b32.valid_out, b32.exponent);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 0;
        repeat (L32 + 2) begin
            @(posedge clk); #1;
            if (b32.valid_out) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errs++;
            $display("FAIL rst_drop: got %0d stray valids want 0", stray);
        end
        run32("post_rst", 8'd131, 8'd127, 1'b0, 1'b0, 8'd131, 0, 0, 0);
    endtask

    task automatic test_params();
        int cyc, lat16, lat64;
        b16.exp_a = 5'd16; b16.exp_b = 5'd15; b16.op_div = 1'b0;
        b16.norm_adj = 1'b0; b16.valid_in = 1'b1;
        b64.exp_a = 11'd1024; b64.exp_b = 11'd1023; b64.op_div = 1'b0;
        b64.norm_adj = 1'b0; b64.valid_in = 1'b1;
        @(posedge clk); #1;
        b16.valid_in = 1'b0; b64.valid_in = 1'b0;
        cyc = 1; lat16 = 0; lat64 = 0;
        while ((lat16 == 0 || lat64 == 0) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (b16.valid_out && lat16 == 0) lat16 = cyc;
            if (b64.valid_out && lat64 == 0) lat64 = cyc;
        end
        checks++;
        if (lat16 !== 4) begin
            errs++;
            $display("FAIL fp16 latency: got %0d want 4", lat16);
        end
        checks++;
        if (lat64 !== 7) begin
            errs++;
            $display("FAIL fp64 latency: got %0d want 7", lat64);
        end
        checks++;
        if ({b16.nan_flag, b16.inf_flag, b16.zero_flag, b16.exponent} !== {3'b000, 5'd16}) begin
            errs++;
            $display("FAIL fp16 result: got e=%0d flags=%b%b%b want e=16 flags=000",
                     b16.exponent, b16.nan_flag, b16.inf_flag, b16.zero_flag);
        end
        checks++;
        if ({b64.nan_flag, b64.inf_flag, b64.zero_flag, b64.exponent} !== {3'b000, 11'd1024}) begin
            errs++;
            $display("FAIL fp64 result: got e=%0d flags=%b%b%b want e=1024 flags=000",
                     b64.exponent, b64.nan_flag, b64.inf_flag, b64.zero_flag);
        end
    endtask

    initial begin
        b32.valid_in = 0; b32.op_div = 0; b32.exp_a = 0; b32.exp_b = 0; b32.norm_adj = 0;
        b16.valid_in = 0; b16.op_div = 0; b16.exp_a = 0; b16.exp_b = 0; b16.norm_adj = 0;
        b64.valid_in = 0; b64.op_div = 0; b64.exp_a = 0; b64.exp_b = 0; b64.norm_adj = 0;
        test_reset();
        @(posedge clk); #1;
        test_mul();
        test_div();
        test_boundary();
        test_back_to_back();
        test_reset_midflight();
        test_params();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
